// File: rtl/ahb_bridge_arbiter_if.sv
// Purpose: request/grant bundle between up to eight AHB masters and the bridge arbiter.
// Latency: none; this is a wiring bundle only.
// Backpressure: hready from the bridge stalls every arbitration decision carried here.
//
// Signals:
//   hbusreq, hlock  per-master bus / locked-access requests
//   htrans          per-master htrans, master i in bits [2i+1:2i]
//   hready          transfer-complete from the bridge (hr_readyout)
//   hgrant          one-hot grant
//   hmaster         address-phase owner index
//   hmaster_data    data-phase owner index (hwdata mux select)
//   hmastlock       current address phase is locked
// The slave modport is the arbiter's view; the master modport is the requester side.
interface ahb_bridge_arbiter_if #(
    parameter int NUM_MASTERS = 4
);
    logic [NUM_MASTERS-1:0]   hbusreq;
    logic [NUM_MASTERS-1:0]   hlock;
    logic [2*NUM_MASTERS-1:0] htrans;
    logic                     hready;
    logic [NUM_MASTERS-1:0]   hgrant;
    logic [2:0]               hmaster;
    logic [2:0]               hmaster_data;
    logic                     hmastlock;

    modport slave (
        input  hbusreq, hlock, htrans, hready,
        output hgrant, hmaster, hmaster_data, hmastlock
    );

    modport master (
        output hbusreq, hlock, htrans, hready,
        input  hgrant, hmaster, hmaster_data, hmastlock
    );
endinterface

// File: rtl/ahb_bridge_arbiter.sv
// Purpose: round-robin arbiter sharing the AHB-to-APB bridge slave port among masters.
// Latency: request to hgrant/hmaster in 1 cycle when parked or released; all outputs registered.
// Backpressure: hready low freezes grant, owner indices, lock flag, beat count and state.
//
// Ports:
//   hclk     clock, all state on rising edge
//   hresetn  asynchronous active-low reset
//   bus      ahb_bridge_arbiter_if.slave (hbusreq, hlock, htrans, hready in;
//            hgrant, hmaster, hmaster_data, hmastlock out)
module ahb_bridge_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int MAX_BEATS      = 8,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    ahb_bridge_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_PARK = 2'd0,
        ST_OWN  = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    localparam logic [2:0] DEF_IDX  = 3'(DEFAULT_MASTER);
    localparam logic [1:0] TR_IDLE  = 2'b00;
    localparam logic [1:0] TR_NSEQ  = 2'b10;

    state_t                 state_q, state_d;
    logic [2:0]             master_q, master_d;
    logic [2:0]             master_data_q, master_data_d;
    logic                   mastlock_q, mastlock_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [7:0]             beat_cnt, beat_cnt_d;

    // Requests widened to the full 3-bit index space so the owner index can
    // select a bit directly; bits at or above NUM_MASTERS read as zero.
    logic [7:0]  req_ext;
    logic [7:0]  lock_ext;
    logic [15:0] trans_ext;
    logic [1:0]  owner_trans;
    logic        beat;
    logic        others_req;
    logic [8:0]  beats_incl;
    logic        cap_hit;
    logic        release_bus;
    logic        win_found;
    logic [2:0]  win_idx;
    logic [2:0]  cand;

    assign req_ext     = 8'(bus.hbusreq);
    assign lock_ext    = 8'(bus.hlock);
    assign trans_ext   = 16'(bus.htrans);
    assign owner_trans = trans_ext[{master_q, 1'b0} +: 2];
    assign beat        = owner_trans[1] & bus.hready;
    assign others_req  = |(req_ext & ~(8'd1 << master_q));
    // The cap counts the beat being accepted on this very edge.
    assign beats_incl  = {1'b0, beat_cnt} + {8'd0, beat};
    assign cap_hit     = (beats_incl >= 9'(MAX_BEATS));
    assign release_bus = !req_ext[master_q]
                       || ((owner_trans == TR_IDLE) && others_req)
                       || (cap_hit && others_req);

    // Round-robin scan owner+1 .. owner+NUM_MASTERS; walking backwards lets
    // the nearest requester overwrite farther ones, and the owner comes last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = master_q;
        cand      = master_q;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            cand = 3'((int'(master_q) + k) % NUM_MASTERS);
            if (req_ext[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        master_d      = master_q;
        master_data_d = master_data_q;
        mastlock_d    = mastlock_q;
        beat_cnt_d    = beat_cnt;
        grant_d       = grant_q;

        if (bus.hready) begin
            unique case (state_q)
                ST_PARK: begin
                    if (win_found) begin
                        master_d = win_idx;
                        state_d  = lock_ext[win_idx] ? ST_LOCK : ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (lock_ext[master_q]) begin
                        state_d = ST_LOCK;
                    end else if (release_bus) begin
                        if (win_found) begin
                            master_d = win_idx;
                            state_d  = lock_ext[win_idx] ? ST_LOCK : ST_OWN;
                        end else begin
                            master_d = DEF_IDX;
                            state_d  = ST_PARK;
                        end
                    end
                end
                ST_LOCK: begin
                    // Unlock only at a sequence boundary so a locked burst is
                    // never split; the owner is kept and OWN rules take over.
                    if (!lock_ext[master_q]
                        && ((owner_trans == TR_IDLE) || (owner_trans == TR_NSEQ))) begin
                        state_d = ST_OWN;
                    end
                end
                default: begin
                    state_d  = ST_PARK;
                    master_d = DEF_IDX;
                end
            endcase

            master_data_d = master_q;
            mastlock_d    = lock_ext[master_q];

            if (master_d != master_q) begin
                beat_cnt_d = 8'd0;
            end else if (beat && (beat_cnt != 8'hFF)) begin
                beat_cnt_d = beat_cnt + 8'd1;
            end

            for (int i = 0; i < NUM_MASTERS; i++) begin
                grant_d[i] = (master_d == 3'(i));
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q       <= ST_PARK;
            master_q      <= DEF_IDX;
            master_data_q <= DEF_IDX;
            mastlock_q    <= 1'b0;
            beat_cnt      <= 8'd0;
            grant_q       <= NUM_MASTERS'(1) << DEFAULT_MASTER;
        end else begin
            state_q       <= state_d;
            master_q      <= master_d;
            master_data_q <= master_data_d;
            mastlock_q    <= mastlock_d;
            beat_cnt      <= beat_cnt_d;
            grant_q       <= grant_d;
        end
    end

    assign bus.hgrant       = grant_q;
    assign bus.hmaster      = master_q;
    assign bus.hmaster_data = master_data_q;
    assign bus.hmastlock    = mastlock_q;

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Purpose: directed, table-driven bench for the round-robin bridge arbiter.
// Latency: each vector is applied between edges and checked 1 ns after the next rising edge.
// Backpressure: hready is driven directly to exercise the wait-state freeze.
module tb_ahb_bridge_arbiter;

    logic hclk;
    logic hresetn;

    ahb_bridge_arbiter_if #(.NUM_MASTERS(4)) bus_if ();

    ahb_bridge_arbiter #(
        .NUM_MASTERS   (4),
        .MAX_BEATS     (8),
        .DEFAULT_MASTER(0)
    ) dut (
        .hclk   (hclk),
        .hresetn(hresetn),
        .bus    (bus_if)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    typedef struct {
        logic [3:0] req;
        logic [3:0] lock;
        logic [7:0] trans;
        logic       ready;
        logic [3:0] g;
        logic [2:0] m;
        logic [2:0] md;
        logic       ml;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] lock,
                         input logic [7:0] trans, input logic ready);
        bus_if.hbusreq = req;
        bus_if.hlock   = lock;
        bus_if.htrans  = trans;
        bus_if.hready  = ready;
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] g, input logic [2:0] m,
                             input logic [2:0] md, input logic ml);
        check({tag, ".hgrant"},       32'(bus_if.hgrant),       32'(g));
        check({tag, ".hmaster"},      32'(bus_if.hmaster),      32'(m));
        check({tag, ".hmaster_data"}, 32'(bus_if.hmaster_data), 32'(md));
        check({tag, ".hmastlock"},    32'(bus_if.hmastlock),    32'(ml));
    endtask

    vec_t tbl[17];

    initial begin
        // htrans per master: IDLE=00 NONSEQ=10 SEQ=11, master i at [2i+1:2i]
        //            req      lock     trans  rdy  grant    m     md    ml
        tbl[0]  = '{4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0001, 3'd0, 3'd0, 1'b0};
        tbl[1]  = '{4'b0100, 4'b0000, 8'h00, 1'b1, 4'b0100, 3'd2, 3'd0, 1'b0};
        tbl[2]  = '{4'b0100, 4'b0000, 8'h20, 1'b1, 4'b0100, 3'd2, 3'd2, 1'b0};
        tbl[3]  = '{4'b0100, 4'b0000, 8'h00, 1'b1, 4'b0100, 3'd2, 3'd2, 1'b0};
        tbl[4]  = '{4'b1011, 4'b0000, 8'h00, 1'b1, 4'b1000, 3'd3, 3'd2, 1'b0};
        tbl[5]  = '{4'b1011, 4'b0000, 8'h80, 1'b1, 4'b1000, 3'd3, 3'd3, 1'b0};
        tbl[6]  = '{4'b0011, 4'b0000, 8'h00, 1'b1, 4'b0001, 3'd0, 3'd3, 1'b0};
        tbl[7]  = '{4'b0010, 4'b0000, 8'h00, 1'b1, 4'b0010, 3'd1, 3'd0, 1'b0};
        tbl[8]  = '{4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0001, 3'd0, 3'd1, 1'b0};
        tbl[9]  = '{4'b0100, 4'b0000, 8'h00, 1'b0, 4'b0001, 3'd0, 3'd1, 1'b0};
        tbl[10] = '{4'b0100, 4'b0000, 8'h00, 1'b1, 4'b0100, 3'd2, 3'd0, 1'b0};
        tbl[11] = '{4'b0100, 4'b0100, 8'h20, 1'b1, 4'b0100, 3'd2, 3'd2, 1'b1};
        tbl[12] = '{4'b1100, 4'b0100, 8'h30, 1'b1, 4'b0100, 3'd2, 3'd2, 1'b1};
        tbl[13] = '{4'b1000, 4'b0000, 8'h30, 1'b1, 4'b0100, 3'd2, 3'd2, 1'b0};
        tbl[14] = '{4'b1000, 4'b0000, 8'h00, 1'b1, 4'b0100, 3'd2, 3'd2, 1'b0};
        tbl[15] = '{4'b1000, 4'b0000, 8'h00, 1'b1, 4'b1000, 3'd3, 3'd2, 1'b0};
        tbl[16] = '{4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0001, 3'd0, 3'd3, 1'b0};

        // Reset and park
        hresetn = 1'b0;
        drive(4'b0000, 4'b0000, 8'h00, 1'b1);
        #12;
        check_all("reset", 4'b0001, 3'd0, 3'd0, 1'b0);
        check("reset.beat_cnt", 32'(dut.beat_cnt), 32'd0);
        hresetn = 1'b1;

        // Directed vector table
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].req, tbl[i].lock, tbl[i].trans, tbl[i].ready);
            step();
            check_all($sformatf("vec%0d", i), tbl[i].g, tbl[i].m, tbl[i].md, tbl[i].ml);
        end

        // Round-robin rotation: all request, all issue SEQ, 8-beat tenures
        drive(4'b1111, 4'b0000, 8'hFF, 1'b1);
        for (int c = 0; c < 40; c++) begin
            logic [2:0] exp_m;
            logic [2:0] prev_m;
            exp_m  = 3'((1 + c / 8) % 4);
            prev_m = (c == 0) ? 3'd0 : 3'((1 + (c - 1) / 8) % 4);
            step();
            check($sformatf("rr%0d.hmaster", c), 32'(bus_if.hmaster), 32'(exp_m));
            check($sformatf("rr%0d.hmaster_data", c), 32'(bus_if.hmaster_data), 32'(prev_m));
        end
        drive(4'b0000, 4'b0000, 8'h00, 1'b1);
        step();
        check_all("rr_park", 4'b0001, 3'd0, 3'd1, 1'b0);

        // Locked sequence: master 1 locked for 12 beats while master 3 requests
        drive(4'b0010, 4'b0010, 8'h08, 1'b1);
        step();
        check_all("lk_grant", 4'b0010, 3'd1, 3'd0, 1'b0);
        drive(4'b1010, 4'b0010, 8'h0C, 1'b1);
        for (int c = 0; c < 12; c++) begin
            step();
            check_all($sformatf("lk%0d", c), 4'b0010, 3'd1, 3'd1, 1'b1);
        end
        drive(4'b1010, 4'b0000, 8'h0C, 1'b1);
        step();
        check_all("lk_seq_hold", 4'b0010, 3'd1, 3'd1, 1'b0);
        drive(4'b1010, 4'b0000, 8'h08, 1'b1);
        step();
        check_all("lk_unlock", 4'b0010, 3'd1, 3'd1, 1'b0);
        step();
        check_all("lk_handoff", 4'b1000, 3'd3, 3'd1, 1'b0);
        drive(4'b0000, 4'b0000, 8'h00, 1'b1);
        step();
        check_all("lk_park", 4'b0001, 3'd0, 3'd3, 1'b0);

        // Wait-state freeze: owner 0 drops during a 5-cycle stall, master 2 waits
        drive(4'b0001, 4'b0000, 8'h00, 1'b1);
        step();
        check_all("ws_own0", 4'b0001, 3'd0, 3'd0, 1'b0);
        drive(4'b0100, 4'b0000, 8'h00, 1'b0);
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("ws%0d.hgrant", c), 32'(bus_if.hgrant), 32'(4'b0001));
            check($sformatf("ws%0d.hmaster", c), 32'(bus_if.hmaster), 32'd0);
        end
        bus_if.hready = 1'b1;
        step();
        check_all("ws_switch", 4'b0100, 3'd2, 3'd0, 1'b0);
        drive(4'b0000, 4'b0000, 8'h00, 1'b1);
        step();
        check_all("ws_park", 4'b0001, 3'd0, 3'd2, 1'b0);

        // Reset mid-tenure: master 3 owns with 5 beats counted
        drive(4'b1000, 4'b0000, 8'h80, 1'b1);
        step();
        check_all("rst_own3", 4'b1000, 3'd3, 3'd0, 1'b0);
        drive(4'b1000, 4'b0000, 8'hC0, 1'b1);
        for (int c = 0; c < 5; c++) step();
        check("rst.beat_cnt_pre", 32'(dut.beat_cnt), 32'd5);
        #3;
        hresetn = 1'b0;
        #1;
        check_all("rst_async", 4'b0001, 3'd0, 3'd0, 1'b0);
        check("rst.beat_cnt", 32'(dut.beat_cnt), 32'd0);
        step();
        hresetn = 1'b1;
        check_all("rst_held", 4'b0001, 3'd0, 3'd0, 1'b0);
        step();
        check_all("rst_regrant", 4'b1000, 3'd3, 3'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_bridge_arbiter.md
# ahb_bridge_arbiter

Round-robin AHB bus arbiter that shares the AHB slave port of the AHB-to-APB bridge among up to eight AHB masters. It sits in front of the bridge's AHB interface and produces the grant, address-phase owner and data-phase owner indices. The external AHB master mux uses those indices to steer haddr/hwrite/hwdata into the bridge. Grant changes only at transfer boundaries (hready high), supports locked sequences, and caps each tenure at a programmable beat count.

## Interface
Parameters:
- NUM_MASTERS, 4: number of requesters, legal range 2..8.
- MAX_BEATS, 8: accepted transfers per tenure before forced re-arbitration, legal range 1..255.
- DEFAULT_MASTER, 0: parking master index, must be < NUM_MASTERS.

Ports:
- hclk  in  1  single clock; all state is updated on its rising edge.
- hresetn  in  1  reset, asynchronous and active-low.
- hbusreq  in  NUM_MASTERS  bus request, one bit per master.
- hlock  in  NUM_MASTERS  locked-access request, one bit per master.
- htrans  in  2*NUM_MASTERS  htrans of each master; master i occupies bits [2i+1:2i].
- hready  in  1  transfer-complete indication from the bridge (its hr_readyout).
- hgrant  out  NUM_MASTERS  one-hot grant.
- hmaster  out  3  address-phase owner index.
- hmaster_data  out  3  data-phase owner index; drives the hwdata mux.
- hmastlock  out  1  current address phase is locked.

## Operation
- Owner = index held in hmaster. owner_trans = htrans slice of the owner. Beat = owner_trans[1]==1 while hready==1 (NONSEQ or SEQ accepted).
- State machine:
  - PARK: no master holds the bus by request; grant sits on DEFAULT_MASTER.
  - OWN: the owner holds the bus by request.
  - LOCK: the owner holds the bus with hlock asserted.
- Decision point: any cycle with hready==1. When hready==0, hgrant, hmaster, hmastlock, the beat counter and the state all hold.
- Release condition at a decision point (OWN only):
  - hbusreq[owner]==0, or
  - owner_trans==IDLE (2'b00) while another master requests, or
  - beat count (including the current beat) >= MAX_BEATS while another master requests.
- Round-robin winner: scan indices owner+1, owner+2, …, wrapping modulo NUM_MASTERS; the first with hbusreq set wins. The owner itself is checked last.
- Transitions, evaluated at decision points:
  - PARK: if any request, winner → hgrant/hmaster; go to LOCK if hlock[winner], else OWN. With no request, stay PARK.
  - OWN: if hlock[owner], go to LOCK. Else on release: pick the winner (OWN/LOCK per its hlock), or go to PARK on DEFAULT_MASTER if nobody requests. Else stay.
  - LOCK: no re-arbitration, and the beat cap is ignored. When hlock[owner]==0 and owner_trans is IDLE or NONSEQ, go to OWN with the same owner, then apply the OWN rules from the next decision point.
- Beat counter: 8 bits. It increments on each beat and clears to 0 when hmaster changes. It saturates at 255.
- hmastlock <= hlock[owner] at each decision point.
- hmaster_data <= hmaster at each decision point.
- Master indices >= NUM_MASTERS are never granted. hbusreq/hlock bits above NUM_MASTERS do not exist.

## Timing
- All outputs are registered.
- Reset (async assert, sync release):
  - hgrant = one-hot DEFAULT_MASTER.
  - hmaster = hmaster_data = DEFAULT_MASTER.
  - hmastlock = 0, beat counter = 0, state = PARK.
- Request to grant latency: 1 cycle when hready==1 and the bus is parked or released. The new hgrant and hmaster appear on the same edge.
- Ownership of data phases: hmaster_data lags hmaster by exactly one accepted transfer. The last data phase of the old owner completes with the old hmaster_data.
- Simultaneous requests: resolved purely by round-robin order from the current owner; there is no fixed priority.
- Request and drop in the same cycle: decisions use the hbusreq values sampled at the decision edge only.
- Wait states: a long hready==0 stall (e.g., an APB access in progress) freezes all arbitration.
- Reset asserted mid-tenure: outputs go to reset values immediately; any in-flight transfer is abandoned.

## Test plan
- Reset and park:
  - Stimulus: hresetn low, then high; hbusreq=0, hready=1.
  - Required: hgrant=4'b0001, hmaster=0, hmastlock=0 throughout.
- Single request:
  - Stimulus: hbusreq=4'b0100 while parked.
  - Required: next edge hgrant=4'b0100, hmaster=2; after one accepted NONSEQ, hmaster_data=2.
- Round-robin rotation:
  - Stimulus: hbusreq=4'b1111, every owner issues continuous SEQ beats, MAX_BEATS=8.
  - Required: grant order 1, 2, 3, 0, 1…; each tenure exactly 8 beats.
- Locked sequence:
  - Stimulus: master 1 granted with hlock=1, issues 12 beats while master 3 requests.
  - Required: no handoff and hmastlock=1 throughout; after hlock drops and a NONSEQ/IDLE occurs, grant moves to 3.
- Wait-state freeze:
  - Stimulus: owner 0 drops hbusreq while hready=0 for 5 cycles, master 2 requesting.
  - Required: hgrant unchanged for those 5 cycles; switches to master 2 on the first hready=1 edge.
- Reset mid-tenure:
  - Stimulus: master 3 owns with beat count 5; hresetn pulsed low asynchronously.
  - Required: hgrant=4'b0001 immediately, beat counter=0; after release, master 3 re-requesting is granted in 1 cycle.
